// File: rtl/axi_burst_mem_responder.sv
// rtl/axi_burst_mem_responder.sv - AXI4 burst memory responder, one outstanding transaction.
// Define AXI_MEM_READ_LATENCY_EN to insert READ_LATENCY wait cycles before R beats / B response.
module axi_burst_mem_responder #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int MEM_WORDS_LOG = 10,
  parameter int READ_LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);

  localparam int OFF   = $clog2(DATA_WIDTH / 8);
  localparam int DEPTH = 1 << MEM_WORDS_LOG;
  localparam logic [2:0] SIZE = 3'(OFF);

  typedef logic [MEM_WORDS_LOG-1:0] idx_t;

`ifdef AXI_MEM_READ_LATENCY_EN
  typedef enum logic [2:0] {IDLE, R_BURST, W_DATA, W_RESP, R_WAIT} state_t;
  localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             wr_q, wr_d;
`else
  typedef enum logic [2:0] {IDLE, R_BURST, W_DATA, W_RESP} state_t;
`endif

  state_t                state_q, state_d;
  idx_t                  start_q, start_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  werr_q, werr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  idx_t len_ext, seq_idx, beat_idx;
  logic last_beat, r_hs, w_hs;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_araddr[ADDR_WIDTH-1:MEM_WORDS_LOG+OFF], s_axi_araddr[OFF-1:0],
                              s_axi_awaddr[ADDR_WIDTH-1:MEM_WORDS_LOG+OFF], s_axi_awaddr[OFF-1:0]};

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size != SIZE) || (burst == 2'b11) || bad_wrap;
  endfunction

  // Outputs are forced low while reset is held so nothing handshakes during it.
  assign s_axi_arready = !reset && (state_q == IDLE);
  assign s_axi_awready = !reset && (state_q == IDLE) && !s_axi_arvalid;
  assign s_axi_rvalid  = !reset && (state_q == R_BURST);
  assign s_axi_wready  = !reset && (state_q == W_DATA);
  assign s_axi_bvalid  = !reset && (state_q == W_RESP);

  assign last_beat   = (cnt_q == len_q);
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign s_axi_rlast = s_axi_rvalid && last_beat;
  assign s_axi_rresp = (s_axi_rvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axi_bresp = (s_axi_bvalid && (err_q || werr_q)) ? 2'b10 : 2'b00;
  assign s_axi_rdata = (s_axi_rvalid && !err_q) ? mem_q[beat_idx] : '0;

  always_comb begin
    len_ext  = idx_t'(len_q);
    seq_idx  = start_q + idx_t'(cnt_q);
    beat_idx = seq_idx;
    case (burst_q)
      2'b00:   beat_idx = start_q;
      2'b10:   beat_idx = (start_q & ~len_ext) | (seq_idx & len_ext);
      default: beat_idx = seq_idx;
    endcase
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    err_d   = err_q;
    werr_d  = werr_q;
`ifdef AXI_MEM_READ_LATENCY_EN
    lat_d   = lat_q;
    wr_d    = wr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_axi_arvalid) begin
          start_d = s_axi_araddr[MEM_WORDS_LOG+OFF-1:OFF];
          len_d   = s_axi_arlen;
          burst_d = s_axi_arburst;
          err_d   = burst_err(s_axi_arsize, s_axi_arburst, s_axi_arlen);
`ifdef AXI_MEM_READ_LATENCY_EN
          state_d = (READ_LATENCY > 0) ? R_WAIT : R_BURST;
          wr_d    = 1'b0;
          lat_d   = '0;
`else
          state_d = R_BURST;
`endif
        end else if (s_axi_awvalid) begin
          start_d = s_axi_awaddr[MEM_WORDS_LOG+OFF-1:OFF];
          len_d   = s_axi_awlen;
          burst_d = s_axi_awburst;
          err_d   = burst_err(s_axi_awsize, s_axi_awburst, s_axi_awlen);
          werr_d  = 1'b0;
          state_d = W_DATA;
        end
      end
      R_BURST: begin
        if (r_hs) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      W_DATA: begin
        if (w_hs) begin
          // The beat count, not wlast, ends the burst; a disagreement only flags an error.
          if (s_axi_wlast != last_beat) werr_d = 1'b1;
          if (last_beat) begin
            cnt_d = '0;
`ifdef AXI_MEM_READ_LATENCY_EN
            state_d = (READ_LATENCY > 0) ? R_WAIT : W_RESP;
            wr_d    = 1'b1;
            lat_d   = '0;
`else
            state_d = W_RESP;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) state_d = IDLE;
      end
`ifdef AXI_MEM_READ_LATENCY_EN
      R_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          state_d = wr_q ? W_RESP : R_BURST;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
`ifdef AXI_MEM_READ_LATENCY_EN
      lat_q   <= '0;
      wr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      werr_q  <= werr_d;
`ifdef AXI_MEM_READ_LATENCY_EN
      lat_q   <= lat_d;
      wr_q    <= wr_d;
`endif
    end
  end

  // Storage survives reset; w_hs is already gated by reset.
  always_ff @(posedge clk) begin
    if (w_hs && !err_q) mem_q[beat_idx] <= s_axi_wdata;
  end

endmodule

// File: doc/axi_burst_mem_responder.md
Name: axi_burst_mem_responder

Overview:
- AXI4 subordinate (responder) memory model that sits on the far side of the cache-to-memory bus master.
- Accepts AR/AW bursts, returns R beats, and accepts W beats followed by a B response.
- Backed by a word-addressed storage array; supports FIXED, INCR and WRAP bursts; one outstanding transaction at a time.
- Used as the memory endpoint for bus/cache simulation and FPGA bring-up.

Parameters:
- DATA_WIDTH, 64: beat width in bits; size field must equal log2(DATA_WIDTH/8), i.e. 3.
- ADDR_WIDTH, 64: address width.
- MEM_WORDS_LOG, 10: log2 of storage depth in DATA_WIDTH words.
- READ_LATENCY, 4: extra cycles before the first R beat / B response (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_araddr  in  ADDR_WIDTH  read byte address
- s_axi_arlen  in  8  read beats minus 1
- s_axi_arsize  in  3  read beat size
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rlast  out  1  final read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
- s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst  in  ADDR_WIDTH/8/3/2  write address channel, same encoding as AR
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wlast  in  1  final write beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready

Behaviour:
- Reset (synchronous, active-high): state IDLE; all ready/valid outputs, rlast, rdata, rresp and bresp are 0. Memory contents are not cleared.
- Reset mid-burst aborts the burst: outputs are 0 after the reset edge, and beats already written stay in memory.
- States: IDLE, R_BURST, W_DATA, W_RESP (plus R_WAIT with the optional feature).
- IDLE:
  - arready=1.
  - awready = !arvalid; reads win when AR and AW are valid in the same cycle.
  - AR handshake: latch start index, len, burst and error flag -> R_BURST.
  - AW handshake (no AR): latch the same fields -> W_DATA.
- Word index = addr[MEM_WORDS_LOG+2:3]. Higher address bits alias (modulo depth); low 3 bits are ignored.
- Beat n index:
  - FIXED: start.
  - INCR: start+n, wrapping modulo depth.
  - WRAP: (start & ~len) | ((start+n) & len).
- Error flag is set if size != 3, burst == 11, or WRAP with len not in {1,3,7,15}.
- R_BURST:
  - rvalid=1 starting the cycle after the AR handshake.
  - rdata = mem[beat index], or 0 if error; rresp = 10 if error else 00.
  - rlast=1 when beat count == len.
  - rdata, rresp and rlast are held stable while rvalid && !rready.
  - Count increments on each R handshake.
  - Handshake with rlast -> IDLE; rvalid=0 on the next cycle, which is also an IDLE cycle.
- W_DATA:
  - wready=1.
  - Each W handshake writes wdata to mem[beat index] unless the error flag is set.
  - Burst ends on the handshake of beat len, regardless of wlast.
  - The protocol-error flag is set if wlast != (count==len) on any beat.
  - Burst end -> W_RESP.
- W_RESP:
  - bvalid=1; bresp = 10 if any error else 00.
  - Hold until bready -> IDLE.
- Read-after-write is coherent: a write beat is visible to any later AR.
- Throughput: 1 beat/cycle with ready held high. Back-to-back bursts have one IDLE cycle between them.

Optional Feature:
- Macro: AXI_MEM_READ_LATENCY_EN.
- Defined:
  - After the AR handshake, the FSM enters R_WAIT for READ_LATENCY cycles with rvalid=0, then enters R_BURST.
  - W_DATA -> R_WAIT -> W_RESP applies the same delay before bvalid.
  - READ_LATENCY=0 behaves as if the macro is undefined.
- Undefined: no R_WAIT state; the latency counter logic is absent.

Test Plan:
- INCR write, then WRAP read:
  - Write AW 0x100, len 7, INCR, data 0xA0..0xA7, then B = OKAY.
  - Read AR 0x110, len 7, WRAP.
  - Required R data: A2,A3,A4,A5,A6,A7,A0,A1; rlast only on the 8th beat; rresp 00.
- R backpressure: toggle rready 1/0 every cycle during an 8-beat INCR read -> rdata/rlast stable across stalls; exactly 8 handshakes; rvalid drops after the last one.
- Simultaneous AR and AW in IDLE:
  - AR handshake first; awready=0 that cycle.
  - AW is accepted after rlast plus one IDLE cycle.
- wlast asserted early on beat 5 of a len-7 write -> all 8 beats are written; bresp=10.
- WRAP read with len 5 -> 6 beats, each with rdata=0 and rresp=10; rlast on beat 6.
- Reset mid read burst:
  - Assert reset at beat 3 -> rvalid=0 after the reset edge.
  - Once reset is released, arready=1 in the first cycle and a new read returns the correct data.
